// File: rtl/acqbuf_axis_capture_if.sv
// ---------------------------------------------------------------------------
// acqbuf_axis_capture_if
// AXI4-stream beat channel feeding the acquisition-buffer writer.
//   tdata  : sample beat (DATA_WIDTH bits)
//   tvalid : beat valid, driven by the stream source
//   tready : beat accept, driven by the sink
// Modports:
//   master : stream source (drives tdata/tvalid, observes tready)
//   slave  : stream sink   (observes tdata/tvalid, drives tready)
// ---------------------------------------------------------------------------
interface acqbuf_axis_capture_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/acqbuf_axis_capture.sv
// ---------------------------------------------------------------------------
// acqbuf_axis_capture
// Writer side of a host-read acquisition buffer. Accepts an ADC AXI4-stream
// (which can never be stalled) and, after a start pulse, writes a programmed
// number of optionally decimated beats into a BRAM write port. Capture begins
// immediately or on the first accepted beat that carries trig=1.
//
// Ports:
//   i_clk        stream / BRAM clock
//   i_aresetn    asynchronous active-low reset
//   s_axis       AXI4-stream slave (tdata, tvalid in; tready out)
//   i_start      1-cycle pulse: latch configuration and begin a capture
//   i_abort      1-cycle pulse: stop and return to idle (wins over start)
//   i_trig_mode  0 = capture immediately, 1 = wait for trigger
//   i_trig       trigger level, looked at only on accepted beats while armed
//   i_length     words to write; 0 selects the full depth 2**ADDR_WIDTH
//   i_decim      write every (decim+1)th accepted beat
//   o_bram_addr  BRAM write address
//   o_bram_din   BRAM write data
//   o_bram_we    BRAM write enable
//   o_busy       high while armed or capturing
//   o_done       high once the capture completed; cleared by start/abort
//   o_wcount     words written in the current / last capture
// ---------------------------------------------------------------------------
module acqbuf_axis_capture #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 12,
    parameter int DECIM_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_aresetn,
    acqbuf_axis_capture_if.slave   s_axis,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic                   i_trig_mode,
    input  logic                   i_trig,
    input  logic [ADDR_WIDTH-1:0]  i_length,
    input  logic [DECIM_WIDTH-1:0] i_decim,
    output logic [ADDR_WIDTH-1:0]  o_bram_addr,
    output logic [DATA_WIDTH-1:0]  o_bram_din,
    output logic                   o_bram_we,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [ADDR_WIDTH:0]    o_wcount
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_tready;
    logic [ADDR_WIDTH-1:0]  r_wptr;
    logic [DECIM_WIDTH-1:0] r_dcnt;
    logic [DECIM_WIDTH-1:0] r_decim;
    logic [ADDR_WIDTH:0]    r_target;
    // Set by the final write; holds CAPTURE one more cycle so done rises
    // in the cycle after the last bram_we rather than alongside it.
    logic                   r_last;

    logic                   w_accept;
    logic [ADDR_WIDTH:0]    w_len_target;
    logic [ADDR_WIDTH:0]    w_wcount_next;
    logic [ADDR_WIDTH-1:0]  w_wptr_next;
    logic [DECIM_WIDTH-1:0] w_dcnt_dec;
    logic                   w_dcnt_zero;

    // Stream is accepted whenever valid; tready only drops in reset.
    assign s_axis.tready = r_tready;
    assign w_accept      = s_axis.tvalid & r_tready;

    // A programmed length of zero means the whole buffer.
    assign w_len_target  = (i_length == {ADDR_WIDTH{1'b0}})
                         ? {1'b1, {ADDR_WIDTH{1'b0}}}
                         : {1'b0, i_length};
    assign w_wcount_next = o_wcount + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign w_wptr_next   = r_wptr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    assign w_dcnt_dec    = r_dcnt - {{(DECIM_WIDTH-1){1'b0}}, 1'b1};
    assign w_dcnt_zero   = (r_dcnt == {DECIM_WIDTH{1'b0}});

    // Capture FSM with registered BRAM port, status and stream-ready outputs.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_state     <= ST_IDLE;
            r_tready    <= 1'b0;
            r_wptr      <= {ADDR_WIDTH{1'b0}};
            r_dcnt      <= {DECIM_WIDTH{1'b0}};
            r_decim     <= {DECIM_WIDTH{1'b0}};
            r_target    <= {(ADDR_WIDTH+1){1'b0}};
            r_last      <= 1'b0;
            o_bram_addr <= {ADDR_WIDTH{1'b0}};
            o_bram_din  <= {DATA_WIDTH{1'b0}};
            o_bram_we   <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_wcount    <= {(ADDR_WIDTH+1){1'b0}};
        end else begin
            r_tready  <= 1'b1;
            // Write enable is a single-cycle strobe per selected beat.
            o_bram_we <= 1'b0;

            if (i_abort) begin
                // wcount is kept so the host can see how far the capture got.
                r_state <= ST_IDLE;
                r_last  <= 1'b0;
                o_busy  <= 1'b0;
                o_done  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (i_start) begin
                            // Mode is consumed here; length/decim are held in
                            // r_target/r_decim until the next start.
                            r_target <= w_len_target;
                            r_decim  <= i_decim;
                            r_wptr   <= {ADDR_WIDTH{1'b0}};
                            r_dcnt   <= {DECIM_WIDTH{1'b0}};
                            r_last   <= 1'b0;
                            o_wcount <= {(ADDR_WIDTH+1){1'b0}};
                            o_done   <= 1'b0;
                            o_busy   <= 1'b1;
                            r_state  <= i_trig_mode ? ST_ARM : ST_CAPTURE;
                        end else begin
                            r_state <= r_state;
                        end
                    end

                    ST_ARM: begin
                        if (w_accept && i_trig) begin
                            o_bram_we   <= 1'b1;
                            o_bram_addr <= r_wptr;
                            o_bram_din  <= s_axis.tdata;
                            r_wptr      <= w_wptr_next;
                            o_wcount    <= w_wcount_next;
                            r_dcnt      <= r_decim;
                            r_last      <= (r_target == {{ADDR_WIDTH{1'b0}}, 1'b1});
                            r_state     <= ST_CAPTURE;
                        end else begin
                            r_state <= ST_ARM;
                        end
                    end

                    ST_CAPTURE: begin
                        if (r_last) begin
                            r_last  <= 1'b0;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (w_accept) begin
                            if (w_dcnt_zero) begin
                                o_bram_we   <= 1'b1;
                                o_bram_addr <= r_wptr;
                                o_bram_din  <= s_axis.tdata;
                                // Wraps to 0 only after the full-depth final word,
                                // and r_last stops further writes at that point.
                                r_wptr      <= w_wptr_next;
                                o_wcount    <= w_wcount_next;
                                r_dcnt      <= r_decim;
                                r_last      <= (w_wcount_next == r_target);
                            end else begin
                                r_dcnt <= w_dcnt_dec;
                            end
                        end else begin
                            r_state <= ST_CAPTURE;
                        end
                    end

                    default: begin
                        r_state <= ST_IDLE;
                        r_last  <= 1'b0;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acqbuf_axis_capture.sv
// ---------------------------------------------------------------------------
// tb_acqbuf_axis_capture
// Directed bench for acqbuf_axis_capture (ADDR_WIDTH=4). A small capture
// model pushes the expected {addr, data} of each write to a queue when a beat
// is driven; a monitor pops and compares on every bram_we.
// ---------------------------------------------------------------------------
module tb_acqbuf_axis_capture;
    localparam int DW  = 64;
    localparam int AW  = 4;
    localparam int DCW = 8;

    logic           clk = 1'b0;
    logic           aresetn;
    logic           start, abort, trig_mode, trig;
    logic [AW-1:0]  length;
    logic [DCW-1:0] decim;
    logic [AW-1:0]  bram_addr;
    logic [DW-1:0]  bram_din;
    logic           bram_we, busy, done;
    logic [AW:0]    wcount;

    always #5 clk = ~clk;

    acqbuf_axis_capture_if #(.DATA_WIDTH(DW)) axis ();

    acqbuf_axis_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DECIM_WIDTH(DCW)) dut (
        .i_clk       (clk),
        .i_aresetn   (aresetn),
        .s_axis      (axis.slave),
        .i_start     (start),
        .i_abort     (abort),
        .i_trig_mode (trig_mode),
        .i_trig      (trig),
        .i_length    (length),
        .i_decim     (decim),
        .o_bram_addr (bram_addr),
        .o_bram_din  (bram_din),
        .o_bram_we   (bram_we),
        .o_busy      (busy),
        .o_done      (done),
        .o_wcount    (wcount)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_w;

    // Reference capture model
    bit m_active, m_armed;
    int m_dcnt, m_cnt, m_target, m_decim;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every write the DUT makes must match the head of the expectation queue.
    always @(negedge clk) begin
        if (bram_we === 1'b1) begin
            check("write_expected", DW'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_w = exp_q.pop_front();
                check("bram_addr", DW'(bram_addr), DW'(mon_w.addr));
                check("bram_din", bram_din, mon_w.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit mode, input int len, input int dec);
        trig_mode = mode;
        length    = AW'(len);
        decim     = DCW'(dec);
        start     = 1'b1;
        step();
        start     = 1'b0;
        // Scramble live config: the latched copy must be used.
        length    = AW'($urandom);
        decim     = DCW'($urandom);
        trig_mode = 1'($urandom);
        m_active  = 1'b1;
        m_armed   = mode;
        m_dcnt    = 0;
        m_cnt     = 0;
        m_target  = (len == 0) ? (1 << AW) : len;
        m_decim   = dec;
    endtask

    task automatic push_write(input logic [DW-1:0] d);
        wr_t w;
        w.addr = AW'(m_cnt);
        w.data = d;
        exp_q.push_back(w);
        m_cnt++;
        m_dcnt = m_decim;
    endtask

    task automatic beat(input logic [DW-1:0] d, input bit t);
        axis.tvalid = 1'b1;
        axis.tdata  = d;
        trig        = t;
        if (m_active) begin
            if (m_armed) begin
                if (t) begin
                    m_armed = 1'b0;
                    push_write(d);
                end
            end else if (m_dcnt == 0) begin
                push_write(d);
            end else begin
                m_dcnt--;
            end
            if (m_cnt == m_target) m_active = 1'b0;
        end
        step();
        axis.tvalid = 1'b0;
        axis.tdata  = 64'hDEAD_BEEF_0000_0000;
        trig        = 1'b0;
    endtask

    task automatic gap();
        axis.tvalid = 1'b0;
        step();
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        check({tag, "_done"}, DW'(done), 64'd1);
        check({tag, "_busy"}, DW'(busy), 64'd0);
        check({tag, "_wcount"}, DW'(wcount), DW'(m_cnt));
        check({tag, "_pending"}, DW'(exp_q.size()), 64'd0);
        step();
    endtask

    initial begin
        aresetn     = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        trig_mode   = 1'b0;
        trig        = 1'b0;
        length      = '0;
        decim       = '0;
        axis.tvalid = 1'b0;
        axis.tdata  = '0;
        m_active    = 1'b0;
        m_armed     = 1'b0;
        m_dcnt      = 0;
        m_cnt       = 0;
        m_target    = 0;
        m_decim     = 0;

        // Reset state
        step();
        step();
        check("rst_tready", DW'(axis.tready), 64'd0);
        check("rst_we", DW'(bram_we), 64'd0);
        check("rst_busy", DW'(busy), 64'd0);
        check("rst_done", DW'(done), 64'd0);
        check("rst_wcount", DW'(wcount), 64'd0);
        aresetn = 1'b1;
        step();
        check("tready_after_rst", DW'(axis.tready), 64'd1);
        check("idle_busy", DW'(busy), 64'd0);

        // T1 immediate, length 4, no decimation; fifth beat not written
        do_start(1'b0, 4, 0);
        check("t1_busy", DW'(busy), 64'd1);
        for (int i = 0; i < 5; i++) beat(64'h10 + 64'(i), 1'b0);
        wait_done("t1");

        // T2 length 3, decim 2: beats 0,3,6
        do_start(1'b0, 3, 2);
        for (int i = 0; i < 9; i++) beat(64'(i), 1'b0);
        wait_done("t2");

        // T3 triggered, length 2; trig on 0x55
        do_start(1'b1, 2, 0);
        for (int i = 0; i < 5; i++) beat(64'h50 + 64'(i), 1'b0);
        check("t3_armed_busy", DW'(busy), 64'd1);
        beat(64'h55, 1'b1);
        beat(64'h56, 1'b0);
        beat(64'h57, 1'b1);
        wait_done("t3");

        // Triggered with length 1 and decimation: single word then done
        do_start(1'b1, 1, 3);
        beat(64'h77, 1'b0);
        beat(64'h78, 1'b1);
        beat(64'h79, 1'b1);
        wait_done("len1_trig");

        // T4 full depth with tvalid 1010; no 17th write
        do_start(1'b0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            beat(64'h100 + 64'(i), 1'b0);
            gap();
        end
        wait_done("t4");
        check("t4_wcount16", DW'(wcount), 64'd16);

        // Start while busy is ignored
        do_start(1'b0, 3, 0);
        beat(64'hA0, 1'b0);
        length = AW'(1);
        start  = 1'b1;
        step();
        start  = 1'b0;
        for (int i = 1; i < 5; i++) beat(64'hA0 + 64'(i), 1'b0);
        wait_done("start_busy");

        // T5 abort after 5 of 10
        do_start(1'b0, 10, 0);
        for (int i = 0; i < 5; i++) beat(64'h200 + 64'(i), 1'b0);
        abort = 1'b1;
        step();
        abort    = 1'b0;
        m_active = 1'b0;
        @(negedge clk);
        check("t5_busy", DW'(busy), 64'd0);
        check("t5_done", DW'(done), 64'd0);
        check("t5_wcount", DW'(wcount), 64'd5);
        check("t5_pending", DW'(exp_q.size()), 64'd0);
        step();
        // Simultaneous start and abort: abort wins
        trig_mode = 1'b0;
        length    = AW'(3);
        decim     = '0;
        start     = 1'b1;
        abort     = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        beat(64'hAA, 1'b0);
        @(negedge clk);
        check("t5_sa_busy", DW'(busy), 64'd0);
        check("t5_sa_wcount", DW'(wcount), 64'd5);
        step();
        do_start(1'b0, 2, 0);
        beat(64'hB0, 1'b0);
        beat(64'hB1, 1'b0);
        beat(64'hB2, 1'b0);
        wait_done("t5_restart");

        // T6 async reset mid-capture
        do_start(1'b0, 8, 0);
        for (int i = 0; i < 3; i++) beat(64'h300 + 64'(i), 1'b0);
        aresetn = 1'b0;
        #1;
        check("t6_we", DW'(bram_we), 64'd0);
        check("t6_busy", DW'(busy), 64'd0);
        check("t6_done", DW'(done), 64'd0);
        check("t6_wcount", DW'(wcount), 64'd0);
        check("t6_tready", DW'(axis.tready), 64'd0);
        exp_q.delete();
        m_active = 1'b0;
        step();
        aresetn = 1'b1;
        step();
        beat(64'h400, 1'b0);
        beat(64'h401, 1'b0);
        @(negedge clk);
        check("t6_tready_back", DW'(axis.tready), 64'd1);
        check("t6_idle_busy", DW'(busy), 64'd0);
        check("t6_idle_wcount", DW'(wcount), 64'd0);
        step();
        do_start(1'b0, 1, 0);
        beat(64'hC0, 1'b0);
        beat(64'hC1, 1'b0);
        wait_done("t6_restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
